// File: rtl/int_to_float32_arbiter.sv
// Shares one int->float32 converter between requesters A (FCVT) and B (FPU issue queue), round-robin.
// Latency: 2 cycles from request acceptance to resp_valid; one conversion per cycle at full rate.
// Backpressure: resp_ready low holds S2 then S1; readies drop when both stages are full. Macro: INT2F32_STICKY_FLAGS_EN.
module int_to_float32_arbiter #(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [63:0]      a_in,
    input  logic [1:0]       a_typeOp,
    input  logic [1:0]       a_rm,
    input  logic [TAG_W-1:0] a_tag,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [63:0]      b_in,
    input  logic [1:0]       b_typeOp,
    input  logic [1:0]       b_rm,
    input  logic [TAG_W-1:0] b_tag,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_src,
    output logic [TAG_W-1:0] resp_tag,
    output logic [31:0]      resp_out,
    output logic [4:0]       resp_flags,
    output logic [4:0]       flags_acc,
    input  logic             flags_clr
);

    // Request-holding stage S1
    logic             s1_valid_q, s1_valid_d;
    logic             s1_src_q, s1_src_d;
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
    logic [63:0]      s1_in_q, s1_in_d;
    logic [1:0]       s1_op_q, s1_op_d;
    logic [1:0]       s1_rm_q, s1_rm_d;

    // Result-holding stage S2
    logic             s2_valid_q, s2_valid_d;
    logic             s2_src_q, s2_src_d;
    logic [TAG_W-1:0] s2_tag_q, s2_tag_d;
    logic [31:0]      s2_out_q, s2_out_d;
    logic [4:0]       s2_flags_q, s2_flags_d;

    // Round-robin pointer: 0 gives A priority, 1 gives B priority
    logic             rr_ptr_q, rr_ptr_d;

    logic s2_free, s1_adv, accept_en, grant_a, grant_b;

    // Conversion datapath signals
    logic        cv_neg, cv_g, cv_s, cv_inc;
    logic [63:0] cv_raw, cv_mag, cv_norm;
    logic [5:0]  cv_lz;
    logic [30:0] cv_body;
    logic [31:0] cvt_out;
    logic [4:0]  cvt_flags;

    // Stage advance and round-robin grant; grant looks only at the valids
    always_comb begin
        s2_free   = !s2_valid_q || resp_ready;
        s1_adv    = s1_valid_q && s2_free;
        accept_en = !s1_valid_q || s1_adv;
        grant_a   = a_valid && (!b_valid || !rr_ptr_q);
        grant_b   = b_valid && (!a_valid || rr_ptr_q);
        a_ready   = accept_en && grant_a;
        b_ready   = accept_en && grant_b;
    end

    // Integer to float32: sign/magnitude, normalise on the leading one, round to 24 significant bits
    always_comb begin
        cv_raw = s1_in_q;
        if (!s1_op_q[1]) begin
            cv_raw = s1_op_q[0] ? {{32{s1_in_q[31]}}, s1_in_q[31:0]} : {32'd0, s1_in_q[31:0]};
        end
        cv_neg = s1_op_q[0] && cv_raw[63];
        cv_mag = cv_neg ? (~cv_raw + 64'd1) : cv_raw;
        cv_lz  = 6'd0;
        for (int i = 0; i < 64; i++) begin
            if (cv_mag[i]) cv_lz = 6'(63 - i);
        end
        cv_norm = cv_mag << cv_lz;
        cv_g    = cv_norm[39];
        cv_s    = |cv_norm[38:0];
        cv_inc  = 1'b0;
        case (s1_rm_q)
            2'd0:    cv_inc = cv_g && (cv_s || cv_norm[40]);
            2'd1:    cv_inc = 1'b0;
            2'd2:    cv_inc = cv_neg && (cv_g || cv_s);
            default: cv_inc = !cv_neg && (cv_g || cv_s);
        endcase
        // Mantissa carry ripples into the exponent field, which is the correct renormalisation
        cv_body = {8'd190 - {2'd0, cv_lz}, cv_norm[62:40]} + {30'd0, cv_inc};
        if (cv_norm[63]) begin
            cvt_out   = {cv_neg, cv_body};
            cvt_flags = {4'd0, cv_g || cv_s};
        end else begin
            cvt_out   = 32'd0;
            cvt_flags = 5'd0;
        end
    end

    // Next state of both holding stages and the round-robin pointer
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_src_d   = s1_src_q;
        s1_tag_d   = s1_tag_q;
        s1_in_d    = s1_in_q;
        s1_op_d    = s1_op_q;
        s1_rm_d    = s1_rm_q;
        s2_valid_d = s2_valid_q;
        s2_src_d   = s2_src_q;
        s2_tag_d   = s2_tag_q;
        s2_out_d   = s2_out_q;
        s2_flags_d = s2_flags_q;
        rr_ptr_d   = rr_ptr_q;
        if (s1_adv) begin
            s2_valid_d = 1'b1;
            s2_src_d   = s1_src_q;
            s2_tag_d   = s1_tag_q;
            s2_out_d   = cvt_out;
            s2_flags_d = cvt_flags;
            s1_valid_d = 1'b0;
        end else if (s2_valid_q && resp_ready) begin
            s2_valid_d = 1'b0;
        end
        if (a_valid && a_ready) begin
            s1_valid_d = 1'b1;
            s1_src_d   = 1'b0;
            s1_tag_d   = a_tag;
            s1_in_d    = a_in;
            s1_op_d    = a_typeOp;
            s1_rm_d    = a_rm;
            rr_ptr_d   = 1'b1;
        end else if (b_valid && b_ready) begin
            s1_valid_d = 1'b1;
            s1_src_d   = 1'b1;
            s1_tag_d   = b_tag;
            s1_in_d    = b_in;
            s1_op_d    = b_typeOp;
            s1_rm_d    = b_rm;
            rr_ptr_d   = 1'b0;
        end
    end

    // Stage and pointer registers; reset drops anything in flight and zeroes the outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_src_q   <= 1'b0;
            s1_tag_q   <= '0;
            s1_in_q    <= 64'd0;
            s1_op_q    <= 2'd0;
            s1_rm_q    <= 2'd0;
            s2_valid_q <= 1'b0;
            s2_src_q   <= 1'b0;
            s2_tag_q   <= '0;
            s2_out_q   <= 32'd0;
            s2_flags_q <= 5'd0;
            rr_ptr_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_src_q   <= s1_src_d;
            s1_tag_q   <= s1_tag_d;
            s1_in_q    <= s1_in_d;
            s1_op_q    <= s1_op_d;
            s1_rm_q    <= s1_rm_d;
            s2_valid_q <= s2_valid_d;
            s2_src_q   <= s2_src_d;
            s2_tag_q   <= s2_tag_d;
            s2_out_q   <= s2_out_d;
            s2_flags_q <= s2_flags_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    assign resp_valid = s2_valid_q;
    assign resp_src   = s2_src_q;
    assign resp_tag   = s2_tag_q;
    assign resp_out   = s2_out_q;
    assign resp_flags = s2_flags_q;

`ifdef INT2F32_STICKY_FLAGS_EN
    logic [4:0] flags_acc_q, flags_acc_d;

    // Clear first, then OR in the delivered flags so a coincident set wins over the old value
    always_comb begin
        flags_acc_d = flags_clr ? 5'd0 : flags_acc_q;
        if (s2_valid_q && resp_ready) flags_acc_d = flags_acc_d | s2_flags_q;
    end

    // Sticky flag register
    always_ff @(posedge clk) begin
        if (reset) flags_acc_q <= 5'd0;
        else       flags_acc_q <= flags_acc_d;
    end

    assign flags_acc = flags_acc_q;
`else
    logic unused_flags_clr;
    assign unused_flags_clr = flags_clr;
    assign flags_acc        = 5'd0;
`endif

endmodule

// File: tb/tb_int_to_float32_arbiter.sv
module tb_int_to_float32_arbiter;
    localparam int TAG_W = 5;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             a_valid = 1'b0, b_valid = 1'b0;
    logic             a_ready, b_ready;
    logic [63:0]      a_in = '0, b_in = '0;
    logic [1:0]       a_typeOp = '0, b_typeOp = '0, a_rm = '0, b_rm = '0;
    logic [TAG_W-1:0] a_tag = '0, b_tag = '0;
    logic             resp_valid, resp_src;
    logic             resp_ready = 1'b0;
    logic [TAG_W-1:0] resp_tag;
    logic [31:0]      resp_out;
    logic [4:0]       resp_flags, flags_acc;
    logic             flags_clr = 1'b0;

    always #5 clk = ~clk;

    int_to_float32_arbiter #(.TAG_W(TAG_W)) dut (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .a_ready(a_ready), .a_in(a_in), .a_typeOp(a_typeOp), .a_rm(a_rm), .a_tag(a_tag),
        .b_valid(b_valid), .b_ready(b_ready), .b_in(b_in), .b_typeOp(b_typeOp), .b_rm(b_rm), .b_tag(b_tag),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_src(resp_src), .resp_tag(resp_tag),
        .resp_out(resp_out), .resp_flags(resp_flags), .flags_acc(flags_acc), .flags_clr(flags_clr)
    );

    typedef struct {
        logic             src;
        logic [TAG_W-1:0] tag;
        logic [31:0]      out;
        logic [4:0]       flg;
        int               e;
    } item_t;

    item_t       sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    bit          prio_b = 1'b0;
    logic [4:0]  acc_m = 5'd0;
    bit          ovr_en = 1'b0;
    logic [31:0] ovr_out = '0;
    logic [4:0]  ovr_flg = '0;
    bit          got_a, got_b;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference conversion: exact integer value, divide down to 24 significant bits, round by remainder
    function automatic logic [36:0] ref_cvt(input logic [63:0] x, input logic [1:0] op, input logic [1:0] rm);
        logic [63:0] v, q, r, half;
        bit neg, inc, inexact;
        int p, sh;
        logic [31:0] bits;
        neg = 1'b0;
        case (op)
            2'd0: v = {32'd0, x[31:0]};
            2'd1: begin
                neg = x[31];
                v = neg ? (64'h1_0000_0000 - {32'd0, x[31:0]}) : {32'd0, x[31:0]};
            end
            2'd2: v = x;
            default: begin
                neg = x[63];
                v = neg ? (64'd0 - x) : x;
            end
        endcase
        if (v == 64'd0) return 37'd0;
        p = 63;
        while (v[p] == 1'b0) p--;
        if (p <= 23) begin
            sh = 0; q = v << (23 - p); r = 64'd0; half = 64'd0;
        end else begin
            sh = p - 23; q = v >> sh; r = v - (q << sh); half = 64'd1 << (sh - 1);
        end
        inexact = (r != 64'd0);
        case (rm)
            2'd0: inc = inexact && ((r > half) || (r == half && q[0]));
            2'd1: inc = 1'b0;
            2'd2: inc = inexact && neg;
            default: inc = inexact && !neg;
        endcase
        q = q + 64'(inc);
        bits = (32'(p + 127) << 23) + q[31:0] - 32'h0080_0000;
        bits[31] = neg;
        return {4'd0, inexact, bits};
    endfunction

    // One clock: entered at negedge with inputs set; checks outputs, advances the model at posedge
    task automatic cycle();
        bit can, ea, eb, ev, hs;
        item_t it;
        logic [36:0] r;
        #1;
        can = (sb.size() < 2) || resp_ready;
        ea = can && a_valid && (!b_valid || !prio_b);
        eb = can && b_valid && (!a_valid || prio_b);
        check_eq("a_ready", a_ready, ea);
        check_eq("b_ready", b_ready, eb);
        ev = (sb.size() > 0) && (sb[0].e + 1 <= cyc);
        check_eq("resp_valid", resp_valid, ev);
        if (ev && resp_valid) begin
            check_eq("resp_src", resp_src, sb[0].src);
            check_eq("resp_tag", resp_tag, sb[0].tag);
            check_eq("resp_out", resp_out, sb[0].out);
            check_eq("resp_flags", resp_flags, sb[0].flg);
        end
        check_eq("flags_acc", flags_acc, acc_m);
        hs = ev && resp_ready;
        got_a = ea;
        got_b = eb;
        it.src = eb;
        it.tag = ea ? a_tag : b_tag;
        r = ea ? ref_cvt(a_in, a_typeOp, a_rm) : ref_cvt(b_in, b_typeOp, b_rm);
        it.out = ovr_en ? ovr_out : r[31:0];
        it.flg = ovr_en ? ovr_flg : r[36:32];
        @(posedge clk);
        cyc++;
`ifdef INT2F32_STICKY_FLAGS_EN
        acc_m = (flags_clr ? 5'd0 : acc_m) | (hs ? sb[0].flg : 5'd0);
`endif
        if (hs) void'(sb.pop_front());
        if (ea || eb) begin
            it.e = cyc;
            sb.push_back(it);
            prio_b = ea;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1; a_valid = 1'b0; b_valid = 1'b0; resp_ready = 1'b0; flags_clr = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        sb.delete();
        prio_b = 1'b0;
        acc_m = 5'd0;
        #1;
        check_eq("rst_resp_valid", resp_valid, 0);
        check_eq("rst_resp_out", resp_out, 0);
        check_eq("rst_resp_tag", resp_tag, 0);
        check_eq("rst_resp_src", resp_src, 0);
        check_eq("rst_resp_flags", resp_flags, 0);
        check_eq("rst_flags_acc", flags_acc, 0);
        check_eq("rst_a_ready", a_ready, 0);
    endtask

    task automatic send(input bit is_b, input logic [63:0] x, input logic [1:0] op, input logic [1:0] rm,
                        input logic [TAG_W-1:0] tag, input logic [31:0] eo, input logic [4:0] ef);
        int n = 0;
        ovr_en = 1'b1; ovr_out = eo; ovr_flg = ef;
        if (is_b) begin
            b_valid = 1'b1; b_in = x; b_typeOp = op; b_rm = rm; b_tag = tag;
        end else begin
            a_valid = 1'b1; a_in = x; a_typeOp = op; a_rm = rm; a_tag = tag;
        end
        got_a = 1'b0; got_b = 1'b0;
        while (!(got_a || got_b) && n < 20) begin
            cycle();
            n++;
        end
        check_eq("send_accepted", got_a || got_b, 1);
        a_valid = 1'b0; b_valid = 1'b0; ovr_en = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        a_valid = 1'b0; b_valid = 1'b0; resp_ready = 1'b1;
        while (sb.size() > 0 && n < 20) begin
            cycle();
            n++;
        end
        check_eq("drain_empty", sb.size(), 0);
    endtask

    function automatic logic [63:0] rand_val();
        logic [63:0] v;
        case ($urandom_range(0, 3))
            0: v = {$urandom, $urandom};
            1: v = 64'($urandom_range(0, 255));
            2: v = (64'd1 << $urandom_range(0, 63)) + 64'($urandom_range(0, 3)) - 64'd1;
            default: v = {32'hFFFF_FFFF, $urandom};
        endcase
        return v;
    endfunction

    initial begin
        int cnt;
        @(negedge clk);
        do_reset();
        resp_ready = 1'b1;

        // Directed conversions
        send(1'b0, 64'h0000_0000_FFFF_FFFF, 2'd1, 2'd0, 5'h15, 32'hBF80_0000, 5'h00);
        drain();
        send(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 2'd2, 2'd0, 5'h0A, 32'h5F80_0000, 5'h01);
        send(1'b1, 64'h0, 2'd2, 2'd0, 5'h0B, 32'h0000_0000, 5'h00);
        drain();
        send(1'b0, 64'h0100_0001, 2'd0, 2'd0, 5'h01, 32'h4B80_0000, 5'h01);
        send(1'b0, 64'h0100_0001, 2'd0, 2'd1, 5'h02, 32'h4B80_0000, 5'h01);
        send(1'b0, 64'h0100_0001, 2'd0, 2'd2, 5'h03, 32'h4B80_0000, 5'h01);
        send(1'b0, 64'h0100_0001, 2'd0, 2'd3, 5'h04, 32'h4B80_0001, 5'h01);
        drain();

        // Contention: alternating grants from reset, one result per cycle
        do_reset();
        resp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a_valid = 1'b1; b_valid = 1'b1;
            a_in = rand_val(); b_in = rand_val();
            a_typeOp = 2'($urandom); b_typeOp = 2'($urandom);
            a_rm = 2'($urandom); b_rm = 2'($urandom);
            a_tag = TAG_W'(i); b_tag = TAG_W'(i + 16);
            cycle();
            check_eq("cont_grant_a", got_a, (i % 2) == 0);
        end
        drain();

        // Backpressure: only two requests fit while the consumer stalls
        resp_ready = 1'b0;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            a_valid = 1'b1; b_valid = 1'b1;
            a_in = rand_val(); b_in = rand_val();
            a_tag = TAG_W'($urandom); b_tag = TAG_W'($urandom);
            cycle();
            if (got_a || got_b) cnt++;
        end
        check_eq("bp_accepted", cnt, 2);
        drain();

        // Reset with both stages full
        resp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a_valid = 1'b1; a_in = rand_val(); a_tag = TAG_W'(i);
            cycle();
        end
        do_reset();
        a_valid = 1'b1; b_valid = 1'b1; resp_ready = 1'b1;
        cycle();
        check_eq("rst_then_grant_a", got_a, 1);
        drain();

        // Sticky flags
        send(1'b0, 64'h0100_0001, 2'd0, 2'd0, 5'h07, 32'h4B80_0000, 5'h01);
        drain();
`ifdef INT2F32_STICKY_FLAGS_EN
        check_eq("sticky_set", flags_acc, 5'h01);
        flags_clr = 1'b1;
        cycle();
        flags_clr = 1'b0;
        check_eq("sticky_clr", flags_acc, 5'h00);
`else
        check_eq("sticky_off", flags_acc, 5'h00);
`endif

        // Randomized traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            a_valid = ($urandom_range(0, 3) != 0);
            b_valid = ($urandom_range(0, 3) != 0);
            a_in = rand_val(); b_in = rand_val();
            a_typeOp = 2'($urandom); b_typeOp = 2'($urandom);
            a_rm = 2'($urandom); b_rm = 2'($urandom);
            a_tag = TAG_W'($urandom); b_tag = TAG_W'($urandom);
            resp_ready = ($urandom_range(0, 9) < 7);
            flags_clr = ($urandom_range(0, 9) == 0);
            cycle();
        end
        flags_clr = 1'b0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
